ifu_fetch_ctl: RTL and testbench

IFU_FETCH_CTL -- requirements
Module: ifu_fetch_ctl

---
 rtl/hxd32_ifu_pkg.sv | 6 +
 rtl/ifu_fetch_out.sv | 37 +++
 rtl/ifu_fetch_ctl.sv | 113 +++++++++++
 tb/tb_ifu_fetch_ctl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hxd32_ifu_pkg.sv
// hxd32_ifu_pkg: shared fetch FSM state enum, instruction size and default reset pc
package hxd32_ifu_pkg;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP} fetch_state_e;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifu_fetch_out.sv
// ifu_fetch_out: delivery registers and hold buffer (in: deliver/from_hold/hold_we strobes, rdata, pc, pc_next; out: inst_valid, inst_data, pc_data, pc_next)
module ifu_fetch_out
  import hxd32_ifu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            deliver_i,
  input  logic            from_hold_i,
  input  logic            hold_we_i,
  input  logic [31:0]     rdata_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_next_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_data_o,
  output logic [XLEN-1:0] pc_data_o,
  output logic [XLEN-1:0] pc_next_o
);
  logic [31:0] hold_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      hold_q       <= '0;
      inst_valid_o <= 1'b0;
      inst_data_o  <= '0;
      pc_data_o    <= '0;
      pc_next_o    <= '0;
    end else begin
      inst_valid_o <= deliver_i;
      if (hold_we_i) hold_q <= rdata_i;
      if (deliver_i) begin
        inst_data_o <= from_hold_i ? hold_q : rdata_i;
        pc_data_o   <= pc_i;
        pc_next_o   <= pc_next_i;
      end
    end
endmodule

// File: rtl/ifu_fetch_ctl.sv
// ifu_fetch_ctl: single-outstanding fetch FSM (in: redirect, stall, imem gnt/rvalid/rdata; out: imem req/addr, inst_valid/inst_data/pc_data/pc_next; IFU_FETCH_CNT_EN adds fetch_cnt_o/drop_cnt_o)
module ifu_fetch_ctl
  import hxd32_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
`ifdef IFU_FETCH_CNT_EN
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     drop_cnt_o,
`endif
  output logic            inst_valid_o,
  output logic [31:0]     inst_data_o,
  output logic [XLEN-1:0] pc_data_o,
  output logic [XLEN-1:0] pc_next_o
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
  fetch_state_e state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, pc_inc, redir_pc;
  logic deliver, from_hold, hold_we;
  assign pc_inc      = pc + XLEN'(INST_BYTES);
  assign redir_pc    = redirect_pc_i & ALIGN_MASK;
  assign imem_req_o  = state == REQ;
  assign imem_addr_o = pc;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    deliver   = 1'b0;
    from_hold = 1'b0;
    hold_we   = 1'b0;
    case (state)
      BOOT: state_nx = REQ;
      REQ: begin
        if (redirect_i) pc_nx = redir_pc;
        if (imem_gnt_i) state_nx = redirect_i ? DROP : WAIT;
      end
      // a redirect before the response arrives still has a request in flight, so it must be drained
      WAIT: begin
        if (redirect_i) begin
          pc_nx    = redir_pc;
          state_nx = imem_rvalid_i ? REQ : DROP;
        end else if (imem_rvalid_i) begin
          hold_we  = stall_i;
          deliver  = !stall_i;
          pc_nx    = stall_i ? pc : pc_inc;
          state_nx = stall_i ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_nx    = redir_pc;
          state_nx = REQ;
        end else if (!stall_i) begin
          deliver   = 1'b1;
          from_hold = 1'b1;
          pc_nx     = pc_inc;
          state_nx  = REQ;
        end
      end
      DROP: begin
        if (redirect_i) pc_nx = redir_pc;
        if (imem_rvalid_i) state_nx = REQ;
      end
      default: state_nx = BOOT;
    endcase
  end
`ifdef IFU_FETCH_CNT_EN
  logic drop;
  assign drop = (state == WAIT && imem_rvalid_i && redirect_i) ||
                (state == HOLD && redirect_i) ||
                (state == DROP && imem_rvalid_i);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      fetch_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      fetch_cnt_o <= fetch_cnt_o + 32'(deliver);
      drop_cnt_o  <= drop_cnt_o + 32'(drop);
    end
`endif
  ifu_fetch_out #(.XLEN(XLEN)) u_out (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .deliver_i   (deliver),
    .from_hold_i (from_hold),
    .hold_we_i   (hold_we),
    .rdata_i     (imem_rdata_i),
    .pc_i        (pc),
    .pc_next_i   (pc_inc),
    .inst_valid_o(inst_valid_o),
    .inst_data_o (inst_data_o),
    .pc_data_o   (pc_data_o),
    .pc_next_o   (pc_next_o)
  );
endmodule

// File: tb/tb_ifu_fetch_ctl.sv
// tb_ifu_fetch_ctl: directed bench with memory model and expected-delivery scoreboard for ifu_fetch_ctl
module tb_ifu_fetch_ctl;
  logic        clk_i = 0;
  logic        rst_n_i = 0;
  logic        redirect_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic        stall_i = 0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 0;
  logic        imem_rvalid_i = 1;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_data_o, pc_data_o, pc_next_o;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt_o, drop_cnt_o;
`endif
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_addr = 0;
  logic        prev_valid = 0;

  ifu_fetch_ctl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
`ifdef IFU_FETCH_CNT_EN
    .fetch_cnt_o(fetch_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
    .inst_valid_o(inst_valid_o), .inst_data_o(inst_data_o), .pc_data_o(pc_data_o), .pc_next_o(pc_next_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // memory returns the word for the most recently granted address
  always @(posedge clk_i) if (imem_req_o && imem_gnt_i) last_addr <= imem_addr_o;
  assign imem_rdata_i = mem(last_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // every delivery must be the next expected pc, carry that address's word, and pc+4 modulo 2^32
  always @(negedge clk_i) begin
    if (rst_n_i && inst_valid_o) begin
      chk("pulse_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: got pc %h expected none", pc_data_o);
      end else chk("deliv_pc", pc_data_o, exp_q.pop_front());
      chk("deliv_inst", inst_data_o, mem(pc_data_o));
      chk("deliv_next", pc_next_o, pc_data_o + 32'd4);
    end
    prev_valid = rst_n_i && inst_valid_o;
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic reset_dut(input logic boot_redir);
    rst_n_i = 0;
    redirect_i = 0;
    redirect_pc_i = 0;
    stall_i = 0;
    imem_gnt_i = 0;
    imem_rvalid_i = 1;
    exp_q.delete();
    repeat (2) tick();
    rst_n_i = 1;
    redirect_i = boot_redir;
    redirect_pc_i = 32'h300;
    tick();
    redirect_i = 0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d pending deliveries expected 0", name, exp_q.size());
    end
  endtask

  task automatic redirect_in_req(input logic [31:0] target);
    redirect_i = 1;
    redirect_pc_i = target;
    tick();
    redirect_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset release, free-running memory: 0, 4, 8
    rst_n_i = 0;
    #3;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    reset_dut(0);
    chk("first_addr", imem_addr_o, 32'h0);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("rst_inst", inst_data_o, 32'h0);
    chk("rst_pc", pc_data_o, 32'h0);
    chk("rst_next", pc_next_o, 32'h0);
    exp_q = '{32'h0, 32'h4, 32'h8};
    imem_gnt_i = 1;
    wait_empty("seq_0_4_8");
    imem_gnt_i = 0;
    chk("seq_next_addr", imem_addr_o, 32'hC);
    repeat (4) tick();
    // stall while the 0x10 response returns
    reset_dut(0);
    redirect_in_req(32'h10);
    chk("stall_addr", imem_addr_o, 32'h10);
    stall_i = 1;
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_valid", {31'd0, inst_valid_o}, 32'd0);
    end
    chk("hold_no_req", {31'd0, imem_req_o}, 32'd0);
    stall_i = 0;
    exp_q.push_back(32'h10);
    wait_empty("stall_release");
    chk("hold_data", inst_data_o, 32'h0010_FFEF ^ 32'h1357_9BDF);
    chk("stall_next_addr", imem_addr_o, 32'h14);
    repeat (4) tick();
    // redirect together with the 0x20 grant
    reset_dut(0);
    redirect_in_req(32'h20);
    redirect_i = 1;
    redirect_pc_i = 32'h200;
    imem_gnt_i = 1;
    tick();
    redirect_i = 0;
    imem_gnt_i = 0;
    chk("drop_no_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("drop_addr", imem_addr_o, 32'h200);
    chk("drop_req", {31'd0, imem_req_o}, 32'd1);
    repeat (4) tick();
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    exp_q.push_back(32'h200);
    wait_empty("after_drop");
    // redirect with rvalid while in WAIT, misaligned target
    reset_dut(0);
    imem_rvalid_i = 0;
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    tick();
    redirect_i = 1;
    redirect_pc_i = 32'h1003;
    imem_rvalid_i = 1;
    tick();
    redirect_i = 0;
    chk("wait_redir_addr", imem_addr_o, 32'h1000);
    repeat (4) tick();
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    exp_q.push_back(32'h1000);
    wait_empty("after_wait_redir");
    // address wrap
    reset_dut(0);
    redirect_in_req(32'hFFFF_FFFC);
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    exp_q.push_back(32'hFFFF_FFFC);
    wait_empty("wrap");
    chk("wrap_next", pc_next_o, 32'h0);
    chk("wrap_addr", imem_addr_o, 32'h0);
    repeat (3) tick();
    // redirect ignored in BOOT; redirect in HOLD drops the buffer
    reset_dut(1);
    chk("boot_ignore", imem_addr_o, 32'h0);
    redirect_in_req(32'h40);
    stall_i = 1;
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    repeat (2) tick();
    redirect_i = 1;
    redirect_pc_i = 32'h80;
    tick();
    redirect_i = 0;
    stall_i = 0;
    chk("hold_redir_addr", imem_addr_o, 32'h80);
    repeat (5) tick();
`ifdef IFU_FETCH_CNT_EN
    reset_dut(0);
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    imem_gnt_i = 1;
    wait_empty("cnt_fetch");
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    redirect_i = 1;
    redirect_pc_i = 32'h500;
    tick();
    redirect_pc_i = 32'h600;
    imem_gnt_i = 1;
    tick();
    redirect_i = 0;
    imem_gnt_i = 0;
    tick();
    chk("fetch_cnt", fetch_cnt_o, 32'd10);
    chk("drop_cnt", drop_cnt_o, 32'd2);
    imem_rvalid_i = 0;
    imem_gnt_i = 1;
    tick();
    imem_gnt_i = 0;
    tick();
    #2 rst_n_i = 0;
    #1;
    chk("arst_fetch_cnt", fetch_cnt_o, 32'd0);
    chk("arst_drop_cnt", drop_cnt_o, 32'd0);
    chk("arst_addr", imem_addr_o, 32'h0);
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    rst_n_i = 1;
    chk("arst_boot_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("arst_req_after", {31'd0, imem_req_o}, 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
